// File: rtl/mem_stage_pkg.sv
// Shared bus widths, field layout and encodings for the memory-access stage.
// Mirrors the definitions the rest of the core takes from mycpu.h.
package mem_stage_pkg;

    localparam int EX_TO_MEM_BUS_WD        = 176;
    localparam int MEM_TO_WB_BUS_WD        = 70;
    localparam int READ_AFTER_WRITE_BUS_WD = 39;

    localparam logic [2:0] LS_LB  = 3'b000;
    localparam logic [2:0] LS_LH  = 3'b001;
    localparam logic [2:0] LS_LW  = 3'b010;
    localparam logic [2:0] LS_LBU = 3'b100;
    localparam logic [2:0] LS_LHU = 3'b101;

    localparam logic [2:0] WDATA_SRC_ALU   = 3'b000;
    localparam logic [2:0] WDATA_SRC_SHIFT = 3'b001;
    localparam logic [2:0] WDATA_SRC_LOAD  = 3'b010;
    localparam logic [2:0] WDATA_SRC_LUI   = 3'b011;
    localparam logic [2:0] WDATA_SRC_AUIPC = 3'b100;

    typedef enum logic [1:0] {
        MEM_STATE_IDLE = 2'd0,
        MEM_STATE_WAIT = 2'd1,
        MEM_STATE_DONE = 2'd2
    } mem_state_e;

    // Field order matches the ex_stage concatenation, MSB first.
    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  ls_type;
        logic        mem_read;
        logic [31:0] alu_result;
        logic [31:0] shift_result;
        logic        rf_write;
        logic [4:0]  rf_waddr;
        logic [2:0]  rf_wdata_src;
        logic [31:0] lui_wdata;
        logic [31:0] auipc_wdata;
        logic [2:0]  pad;
    } ex_to_mem_t;

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load-data alignment: shifts the addressed byte/halfword down to bit 0 and
// sign- or zero-extends it according to the load type.
module mem_stage_load_ext
    import mem_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  n,
    input  logic [2:0]  ls_type,
    output logic [31:0] data
);

    logic [31:0] shifted;

    // Misaligned lh/lw simply use whatever the shift leaves in the low bits.
    assign shifted = word >> {n, 3'b000};

    // NOTE: default assigned first so every path writes data and no latch is inferred.
    always_comb begin
        data = '0;
        case (ls_type)
            LS_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
            LS_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
            LS_LW:   data = shifted;
            LS_LBU:  data = {24'd0, shifted[7:0]};
            LS_LHU:  data = {16'd0, shifted[15:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the EX bus, waits for the data-SRAM
// response on loads, extends load data and produces the WB and forwarding buses.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               wb_allow_in,
    output logic                               mem_allow_in,
    input  logic                               ex_to_mem_valid,
    input  logic [EX_TO_MEM_BUS_WD-1:0]        ex_to_mem_bus,
    output logic                               mem_to_wb_valid,
    output logic [MEM_TO_WB_BUS_WD-1:0]        mem_to_wb_bus,
    output logic [READ_AFTER_WRITE_BUS_WD-1:0] mem_read_after_write_bus,
    input  logic [31:0]                        Read_data,
    input  logic                               Read_data_Valid,
    output logic                               Read_data_Ready
);

    ex_to_mem_t  ex_in;
    ex_to_mem_t  bus_r;
    mem_state_e  state;
    mem_state_e  state_nxt;
    logic        mem_valid;
    logic        mem_ready_go;
    logic        load_enter;
    logic        resp_fire;
    logic [31:0] load_r;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;
    logic        unused_pad;

    assign ex_in      = ex_to_mem_bus;
    assign unused_pad = ^bus_r.pad;

    assign mem_ready_go    = !bus_r.mem_read || (state == MEM_STATE_DONE);
    assign mem_allow_in    = !mem_valid || (mem_ready_go && wb_allow_in);
    assign mem_to_wb_valid = mem_valid && mem_ready_go;
    assign load_enter      = ex_to_mem_valid && mem_allow_in && ex_in.mem_read;
    assign Read_data_Ready = mem_valid && (state == MEM_STATE_WAIT);
    assign resp_fire       = Read_data_Ready && Read_data_Valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_valid <= 1'b0;
            // NOTE: the bus register is reset too, so mem_read reads 0 and
            // data_ready/the forwarding bus are defined straight out of reset.
            bus_r     <= '0;
        end else if (mem_allow_in) begin
            mem_valid <= ex_to_mem_valid;
            if (ex_to_mem_valid) begin
                bus_r <= ex_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= MEM_STATE_IDLE;
            load_r <= '0;
        end else begin
            state <= state_nxt;
            if (resp_fire) begin
                load_r <= Read_data;
            end
        end
    end

    // DONE hands straight over to WAIT when a new load is accepted the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            MEM_STATE_IDLE: if (load_enter) state_nxt = MEM_STATE_WAIT;
            MEM_STATE_WAIT: if (resp_fire) state_nxt = MEM_STATE_DONE;
            MEM_STATE_DONE: if (wb_allow_in) state_nxt = load_enter ? MEM_STATE_WAIT
                                                                     : MEM_STATE_IDLE;
            default:        state_nxt = MEM_STATE_IDLE;
        endcase
    end

    mem_stage_load_ext u_load_ext (
        .word    (load_r),
        .n       (bus_r.alu_result[1:0]),
        .ls_type (bus_r.ls_type),
        .data    (load_data)
    );

    always_comb begin
        rf_wdata = '0;
        case (bus_r.rf_wdata_src)
            WDATA_SRC_ALU:   rf_wdata = bus_r.alu_result;
            WDATA_SRC_SHIFT: rf_wdata = bus_r.shift_result;
            WDATA_SRC_LOAD:  rf_wdata = load_data;
            WDATA_SRC_LUI:   rf_wdata = bus_r.lui_wdata;
            WDATA_SRC_AUIPC: rf_wdata = bus_r.auipc_wdata;
            default:         rf_wdata = '0;
        endcase
    end

    assign mem_to_wb_bus = {bus_r.pc, bus_r.rf_write, bus_r.rf_waddr, rf_wdata};

    // x0 writes are left visible here; wb_stage masks them.
    assign mem_read_after_write_bus = {mem_valid && bus_r.rf_write, mem_ready_go,
                                       bus_r.rf_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// load/ALU traffic checked against an arithmetic model of the stage's rules.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         wb_allow_in;
    logic         mem_allow_in;
    logic         ex_to_mem_valid;
    logic [175:0] ex_to_mem_bus;
    logic         mem_to_wb_valid;
    logic [69:0]  mem_to_wb_bus;
    logic [38:0]  mem_read_after_write_bus;
    logic [31:0]  Read_data;
    logic         Read_data_Valid;
    logic         Read_data_Ready;

    int vectors = 0;
    int errors  = 0;
    logic [31:0] model_word = 32'd0;  // last word the SRAM handshake accepted

    always #5 clk = ~clk;

    mem_stage dut (
        .clk                      (clk),
        .reset                    (reset),
        .wb_allow_in              (wb_allow_in),
        .mem_allow_in             (mem_allow_in),
        .ex_to_mem_valid          (ex_to_mem_valid),
        .ex_to_mem_bus            (ex_to_mem_bus),
        .mem_to_wb_valid          (mem_to_wb_valid),
        .mem_to_wb_bus            (mem_to_wb_bus),
        .mem_read_after_write_bus (mem_read_after_write_bus),
        .Read_data                (Read_data),
        .Read_data_Valid          (Read_data_Valid),
        .Read_data_Ready          (Read_data_Ready)
    );

    logic [31:0] wb_pc, wb_wdata;
    logic [4:0]  wb_waddr;
    logic        raw_write_valid, raw_data_ready;
    assign wb_pc           = mem_to_wb_bus[69:38];
    assign wb_waddr        = mem_to_wb_bus[36:32];
    assign wb_wdata        = mem_to_wb_bus[31:0];
    assign raw_write_valid = mem_read_after_write_bus[38];
    assign raw_data_ready  = mem_read_after_write_bus[37];

    function automatic logic [175:0] make_bus(input logic [31:0] pc, input logic [2:0] ls,
                                              input logic rd, input logic [31:0] alu,
                                              input logic [31:0] sh, input logic rfw,
                                              input logic [4:0] wa, input logic [2:0] src,
                                              input logic [31:0] lui, input logic [31:0] auipc);
        return {pc, ls, rd, alu, sh, rfw, wa, src, lui, auipc, 3'b000};
    endfunction

    // Load result from the ISA rules: pick the addressed unit, then extend it.
    function automatic logic [31:0] model_load(input logic [31:0] word, input int n,
                                               input logic [2:0] ls);
        longint v = longint'(word) / (longint'(1) << (8 * n));
        longint b = v % 256;
        longint h = v % 65536;
        case (ls)
            3'b000:  return 32'((b >= 128) ? b - 256 : b);
            3'b001:  return 32'((h >= 32768) ? h - 65536 : h);
            3'b010:  return 32'(v);
            3'b100:  return 32'(b);
            3'b101:  return 32'(h);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] src, input logic [31:0] alu,
                                                input logic [31:0] sh, input logic [31:0] ld,
                                                input logic [31:0] lui, input logic [31:0] auipc);
        case (src)
            3'd0:    return alu;
            3'd1:    return sh;
            3'd2:    return ld;
            3'd3:    return lui;
            3'd4:    return auipc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One instruction through the stage: entry, optional WAIT of delay+1 cycles,
    // stall cycles at the WB boundary (with stray responses), then acceptance.
    task automatic run_op(input logic [175:0] bus, input logic [31:0] word, input int delay,
                          input int stall, input logic [31:0] exp, input string tag);
        logic is_load = bus[140];
        tick();
        ex_to_mem_valid = 1'b1; ex_to_mem_bus = bus; wb_allow_in = 1'b1; #1;
        vectors++; if (mem_allow_in !== 1'b1) begin errors++; $display("FAIL %s entry_allow got %b exp 1", tag, mem_allow_in); end
        tick();
        ex_to_mem_valid = 1'b0;
        if (is_load) begin
            for (int i = 0; i <= delay; i++) begin
                Read_data_Valid = (i == delay);
                Read_data       = (i == delay) ? word : $urandom;
                #1;
                vectors++; if (Read_data_Ready !== 1'b1) begin errors++; $display("FAIL %s wait_ready got %b exp 1", tag, Read_data_Ready); end
                vectors++; if ({mem_to_wb_valid, raw_data_ready} !== 2'b00) begin errors++; $display("FAIL %s wait_valid_dready got %b exp 00", tag, {mem_to_wb_valid, raw_data_ready}); end
                tick();
            end
            model_word = word;
        end
        for (int s = 0; s < stall; s++) begin
            wb_allow_in = 1'b0; Read_data_Valid = 1'b1; Read_data = $urandom; #1;
            vectors++; if ({mem_to_wb_valid, mem_allow_in, Read_data_Ready} !== 3'b100) begin errors++; $display("FAIL %s stall_ctrl got %b exp 100", tag, {mem_to_wb_valid, mem_allow_in, Read_data_Ready}); end
            vectors++; if (wb_wdata !== exp) begin errors++; $display("FAIL %s stall_wdata got %h exp %h", tag, wb_wdata, exp); end
            tick();
        end
        wb_allow_in = 1'b1; Read_data_Valid = 1'b0; #1;
        vectors++; if ({mem_to_wb_valid, mem_allow_in, Read_data_Ready} !== 3'b110) begin errors++; $display("FAIL %s accept_ctrl got %b exp 110", tag, {mem_to_wb_valid, mem_allow_in, Read_data_Ready}); end
        vectors++; if (wb_wdata !== exp) begin errors++; $display("FAIL %s wdata got %h exp %h", tag, wb_wdata, exp); end
        vectors++; if ({wb_pc, wb_waddr} !== {bus[175:144], bus[74:70]}) begin errors++; $display("FAIL %s pc_waddr got %h/%0d exp %h/%0d", tag, wb_pc, wb_waddr, bus[175:144], bus[74:70]); end
        vectors++; if ({raw_write_valid, raw_data_ready, mem_read_after_write_bus[31:0]} !== {bus[75], 1'b1, exp}) begin errors++; $display("FAIL %s raw_bus got %b/%b/%h exp %b/1/%h", tag, raw_write_valid, raw_data_ready, mem_read_after_write_bus[31:0], bus[75], exp); end
        tick();
        vectors++; if (mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL %s single_transfer got %b exp 0", tag, mem_to_wb_valid); end
    endtask

    task automatic test_reset();
        reset = 1'b0; wb_allow_in = 1'b1; ex_to_mem_valid = 1'b0; ex_to_mem_bus = '0;
        Read_data = '0; Read_data_Valid = 1'b0;
        repeat (3) tick();
        vectors++; if ({mem_to_wb_valid, Read_data_Ready, mem_allow_in} !== 3'b001) begin errors++; $display("FAIL reset_ctrl got %b exp 001", {mem_to_wb_valid, Read_data_Ready, mem_allow_in}); end
        vectors++; if (mem_read_after_write_bus !== {1'b0, 1'b1, 37'd0}) begin errors++; $display("FAIL reset_raw got %h exp %h", mem_read_after_write_bus, {1'b0, 1'b1, 37'd0}); end
        #2 reset = 1'b1;
        tick();
        vectors++; if ({mem_to_wb_valid, Read_data_Ready, raw_data_ready} !== 3'b001) begin errors++; $display("FAIL post_reset got %b exp 001", {mem_to_wb_valid, Read_data_Ready, raw_data_ready}); end
    endtask

    task automatic test_alu_no_load();
        run_op(make_bus(32'h1000_0000, 3'b010, 1'b0, 32'h1234_5678, 32'hAAAA_0001, 1'b1, 5'd7,
                        3'b000, 32'h5555_0000, 32'h6666_0000), 32'd0, 0, 0, 32'h1234_5678, "alu");
        run_op(make_bus(32'h1000_0004, 3'b000, 1'b0, 32'h0, 32'hAAAA_0001, 1'b1, 5'd0,
                        3'b001, 32'h5555_0000, 32'h6666_0000), 32'd0, 0, 1, 32'hAAAA_0001, "shift_x0");
        run_op(make_bus(32'h1000_0008, 3'b000, 1'b0, 32'h0, 32'h1, 1'b0, 5'd3,
                        3'b111, 32'h5555_0000, 32'h6666_0000), 32'd0, 0, 0, 32'd0, "src_bad");
    endtask

    task automatic test_load_ext();
        run_op(make_bus(32'h2000_0000, 3'b000, 1'b1, 32'h0000_0103, 32'h0, 1'b1, 5'd5,
                        3'b010, 32'h0, 32'h0), 32'h80AA_BBCC, 1, 0, 32'hFFFF_FF80, "lb_off3");
        run_op(make_bus(32'h2000_0004, 3'b101, 1'b1, 32'h0000_0202, 32'h0, 1'b1, 5'd6,
                        3'b010, 32'h0, 32'h0), 32'hF00D_1234, 0, 0, 32'h0000_F00D, "lhu_off2");
        run_op(make_bus(32'h2000_0008, 3'b001, 1'b1, 32'h0000_0300, 32'h0, 1'b1, 5'd8,
                        3'b010, 32'h0, 32'h0), 32'h0000_8001, 2, 0, 32'hFFFF_8001, "lh_off0");
    endtask

    task automatic test_wb_stall();
        logic [31:0] w = $urandom;
        run_op(make_bus(32'h3000_0000, 3'b010, 1'b1, 32'h0000_0040, 32'h0, 1'b1, 5'd9,
                        3'b010, 32'h0, 32'h0), w, 0, 3, w, "lw_stall3");
    endtask

    task automatic test_back_to_back();
        logic [31:0] w1 = $urandom, w2 = $urandom;
        logic [175:0] b1 = make_bus(32'h4000_0000, 3'b010, 1'b1, 32'h100, 32'h0, 1'b1, 5'd1, 3'b010, 32'h0, 32'h0);
        logic [175:0] b2 = make_bus(32'h4000_0004, 3'b010, 1'b1, 32'h104, 32'h0, 1'b1, 5'd2, 3'b010, 32'h0, 32'h0);
        tick();
        ex_to_mem_valid = 1'b1; ex_to_mem_bus = b1; wb_allow_in = 1'b1;
        tick();
        ex_to_mem_valid = 1'b0; Read_data_Valid = 1'b1; Read_data = w1; #1;
        vectors++; if (Read_data_Ready !== 1'b1) begin errors++; $display("FAIL b2b_wait1 got %b exp 1", Read_data_Ready); end
        tick();
        ex_to_mem_valid = 1'b1; ex_to_mem_bus = b2; Read_data = ~w2; #1;
        vectors++; if ({mem_to_wb_valid, mem_allow_in, wb_wdata} !== {2'b11, w1}) begin errors++; $display("FAIL b2b_first got %b%b/%h exp 11/%h", mem_to_wb_valid, mem_allow_in, wb_wdata, w1); end
        tick();
        ex_to_mem_valid = 1'b0; Read_data = w2; #1;
        vectors++; if ({Read_data_Ready, mem_to_wb_valid, raw_data_ready} !== 3'b100) begin errors++; $display("FAIL b2b_no_idle got %b exp 100", {Read_data_Ready, mem_to_wb_valid, raw_data_ready}); end
        tick();
        Read_data_Valid = 1'b0; #1;
        vectors++; if ({mem_to_wb_valid, wb_pc, wb_wdata} !== {1'b1, 32'h4000_0004, w2}) begin errors++; $display("FAIL b2b_second got %b/%h/%h exp 1/40000004/%h", mem_to_wb_valid, wb_pc, wb_wdata, w2); end
        model_word = w2;
        tick();
        vectors++; if (mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", mem_to_wb_valid); end
    endtask

    task automatic test_reset_mid_wait();
        tick();
        ex_to_mem_valid = 1'b1; wb_allow_in = 1'b1;
        ex_to_mem_bus = make_bus(32'h5000_0000, 3'b010, 1'b1, 32'h0, 32'h0, 1'b1, 5'd4, 3'b010, 32'h0, 32'h0);
        tick();
        ex_to_mem_valid = 1'b0; #1;
        vectors++; if (Read_data_Ready !== 1'b1) begin errors++; $display("FAIL rst_wait_ready got %b exp 1", Read_data_Ready); end
        #2 reset = 1'b0; #1;
        vectors++; if ({Read_data_Ready, mem_to_wb_valid, raw_write_valid, raw_data_ready} !== 4'b0001) begin errors++; $display("FAIL rst_async got %b exp 0001", {Read_data_Ready, mem_to_wb_valid, raw_write_valid, raw_data_ready}); end
        Read_data_Valid = 1'b1; Read_data = 32'hDEAD_BEEF;
        tick();
        reset = 1'b1; #1;
        vectors++; if ({Read_data_Ready, mem_to_wb_valid} !== 2'b00) begin errors++; $display("FAIL rst_release got %b exp 00", {Read_data_Ready, mem_to_wb_valid}); end
        tick();
        vectors++; if (Read_data_Ready !== 1'b0) begin errors++; $display("FAIL rst_idle got %b exp 0", Read_data_Ready); end
        Read_data_Valid = 1'b0;
        model_word = 32'd0;
        run_op(make_bus(32'h5000_0004, 3'b010, 1'b0, 32'h0, 32'h0, 1'b1, 5'd4, 3'b010, 32'h0, 32'h0),
               32'd0, 0, 0, 32'd0, "rst_no_capture");
    endtask

    task automatic test_random();
        logic [2:0] ls_list [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        for (int k = 0; k < 40; k++) begin
            logic        ld    = 1'($urandom_range(0, 1));
            logic [2:0]  ls    = ls_list[$urandom_range(0, 7)];
            logic [31:0] alu   = $urandom;
            logic [31:0] sh    = $urandom;
            logic [31:0] lui   = $urandom;
            logic [31:0] auipc = $urandom;
            logic [31:0] word  = $urandom;
            logic [2:0]  src   = ld ? 3'b010 : 3'($urandom_range(0, 7));
            logic [31:0] ext   = model_load(ld ? word : model_word, int'(alu % 4), ls);
            run_op(make_bus($urandom, ls, ld, alu, sh, 1'($urandom), 5'($urandom), src, lui, auipc),
                   word, $urandom_range(0, 3), $urandom_range(0, 2),
                   model_wdata(src, alu, sh, ext, lui, auipc), ld ? "rand_load" : "rand_alu");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_no_load();
        test_load_ext();
        test_wb_stall();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline, between ex_stage and wb_stage.
- Latches ex_to_mem_bus and waits for the data-SRAM read response when the instruction is a load.
- Sign- or zero-extends the loaded byte, halfword or word, and selects the final RF write data.
- Produces mem_to_wb_bus and the mem_read_after_write_bus forwarding/interlock bus to id_stage.

Parameters:
- None. Bus widths come from mycpu.h.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- wb_allow_in  in  1  wb_stage can accept this cycle
- mem_allow_in  out  1  to ex_stage
- ex_to_mem_valid  in  1  ex_stage output valid
- ex_to_mem_bus  in  `EX_TO_MEM_BUS_WD (176)  {pc, ls_type[2:0], mem_read, alu_result, shift_result, RF_write, RF_waddr[4:0], RF_wdata_src[2:0], lui_wdata, auipc_wdata, 3'b000}
- mem_to_wb_valid  out  1  to wb_stage
- mem_to_wb_bus  out  `MEM_TO_WB_BUS_WD (70)  {pc, RF_write, RF_waddr, RF_wdata}
- mem_read_after_write_bus  out  `READ_AFTER_WRITE_BUS_WD (39)  {write_valid, data_ready, RF_waddr, RF_wdata}
- Read_data  in  32  SRAM read word
- Read_data_Valid  in  1  response valid
- Read_data_Ready  out  1  response accept

Behaviour:
- Pipeline control:
  - mem_valid resets to 0.
  - When mem_allow_in is 1: mem_valid <= ex_to_mem_valid, and the bus register loads only when ex_to_mem_valid is 1.
  - mem_allow_in = !mem_valid || (mem_ready_go && wb_allow_in).
  - mem_to_wb_valid = mem_valid && mem_ready_go.
- Load FSM, three states. Reset value is IDLE.
  - IDLE: a new load entering (ex_to_mem_valid && mem_allow_in && mem_read field set) -> WAIT.
  - WAIT: Read_data_Ready = 1. On Read_data_Valid, capture Read_data into load_r -> DONE.
  - DONE: hold load_r. Leave when wb_allow_in is 1: go to WAIT if a new load enters that cycle, otherwise IDLE.
- Read_data_Ready = mem_valid && state==WAIT. It resets to 0 and is never high in IDLE or DONE.
- mem_ready_go = !mem_read || state==DONE. A non-load therefore passes in 1 cycle with no stall. A load's minimum latency is response cycle + 1.
- Load extension:
  - Byte offset n = alu_result[1:0]. Selected data is load_r >> (8*n).
  - ls_type encoding: 000 lb (sign-extend 8), 001 lh (sign-extend 16), 010 lw, 100 lbu, 101 lhu.
  - Any other ls_type gives 0.
  - lh/lhu with n=1 or 3, and lw with n!=0, are undefined upstream; the block must simply use the shifted value and must not hang.
- RF_wdata_src mux: 000 alu_result, 001 shift_result, 010 extended load, 011 lui_wdata, 100 auipc_wdata; any other code gives 0.
- Forwarding bus:
  - write_valid = mem_valid && RF_write.
  - data_ready = !mem_read || state==DONE. id_stage stalls when 0.
  - RF_wdata is driven combinationally from the same mux.
- Reset outputs: mem_to_wb_valid = 0, Read_data_Ready = 0, write_valid = 0, data_ready = 1, state = IDLE, load_r = 0.
- Boundaries:
  - Response arriving while wb is stalled: data is held in DONE until accepted. Read_data_Valid is ignored outside WAIT.
  - Back-to-back loads: DONE->WAIT with no idle cycle.
  - Reset asserted mid-WAIT: return to IDLE immediately. A late response is ignored because Ready is 0.
  - RF_waddr = x0: write_valid is still driven as computed; wb_stage masks the write.

Decomposition:
- mycpu.h defines:
  - EX_TO_MEM_BUS_WD = 176, MEM_TO_WB_BUS_WD = 70, READ_AFTER_WRITE_BUS_WD = 39
  - LS_* type codes
  - WDATA_SRC_* codes
  - MEM_STATE_IDLE/WAIT/DONE (2-bit)
- One sub-module, load_ext: combinational byte/halfword select and sign extension (inputs word, n, ls_type; output 32-bit).

Test Plan:
- ALU op, no load: alu_result=0x12345678, src 000, wb_allow_in=1 -> mem_to_wb_valid 1 cycle after entry, RF_wdata=0x12345678, Read_data_Ready stays 0.
- lb, addr offset 3, Read_data=0x80AABBCC, Valid 2 cycles after entry -> RF_wdata=0xFFFFFF80; data_ready=0 until DONE.
- lhu, offset 2, Read_data=0xF00D1234 -> 0x0000F00D; lh, offset 0, word 0x00008001 -> 0xFFFF8001.
- Load completes while wb_allow_in=0 for 3 cycles -> state DONE held, mem_allow_in=0, RF_wdata stable; a second Valid pulse is ignored; on release, one transfer only.
- Back-to-back lw/lw with Valid on consecutive cycles -> no IDLE between; both words delivered in order.
- Reset driven low during WAIT, then a Valid pulse -> Ready=0 and valid=0 immediately (asynchronous); the pulse is not captured and state is IDLE after release.
